video_timing_gen: RTL
=====================

# video_timing_gen

Raster timing generator for the pong display pipeline. It produces the horizontal and vertical pixel pointers (H_CNT, V_CNT) that the pixel drawer consumes, plus HSYNC, VSYNC and data-enable for the video output. It also emits frame and line strobes for the game-logic blocks. It supplies sync/DE copies delayed to line up with the drawer's registered RGB.

## Interface
Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, HSYNC active level
- VS_POL, 1, VSYNC active level
- PIPE_DLY, 1, delay in enabled cycles applied to the *_D outputs (≥1)

Ports:
- CLK  in  1  pixel clock, 75 MHz
- RST_N  in  1  asynchronous, active-low reset
- EN  in  1  advance raster when high
- H_CNT  out  11  horizontal pixel pointer
- V_CNT  out  11  vertical pixel pointer
- DE  out  1  pointer is inside the active area
- HSYNC, VSYNC  out  1 each  sync for the current pointer, polarity per HS_POL/VS_POL
- LINE_START  out  1  pulse while H_CNT==0
- FRAME_START  out  1  pulse while H_CNT==0 && V_CNT==0
- FRAME_END  out  1  pulse at the last active pixel (H_ACTIVE-1, V_ACTIVE-1)
- DE_D, HSYNC_D, VSYNC_D  out  1 each  DE/HSYNC/VSYNC delayed by PIPE_DLY

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined the same way. Elaboration fails if any parameter is 0, or if H_TOTAL or V_TOTAL exceeds 2048.
- Horizontal phase FSM: ACT → FP → SYNC → BP → ACT.
  - A phase counter drives each transition; it reloads on phase entry.
  - ACT covers H_CNT 0..H_ACTIVE-1. SYNC covers H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC-1.
- Vertical phase FSM: same four states, counted in lines. It advances only on the H_CNT wrap from H_TOTAL-1 to 0.
- Counter advance on an enabled edge:
  - H_CNT increments and wraps from H_TOTAL-1 to 0.
  - On the H wrap, V_CNT increments and wraps from V_TOTAL-1 to 0.
- All outputs are registered, computed from the next pointer value, and describe the pixel currently on H_CNT/V_CNT.
- Output definitions:
  - DE = horizontal ACT && vertical ACT.
  - HSYNC = HS_POL when in horizontal SYNC, else !HS_POL.
  - VSYNC = VS_POL when in vertical SYNC. It changes only together with an H_CNT 0 transition.
- EN low: pointers, FSMs, DE/sync levels and the delay line all hold. LINE_START, FRAME_START and FRAME_END are forced to 0.
- Reset values, applied immediately and asynchronously:
  - H_CNT = H_TOTAL-1, V_CNT = V_TOTAL-1.
  - Both FSMs in BP.
  - DE = 0, HSYNC = !HS_POL, VSYNC = !VS_POL.
  - All strobes 0; DE_D = 0, HSYNC_D = !HS_POL, VSYNC_D = !VS_POL.
- Delay line: PIPE_DLY-stage shift register per signal, filled with the inactive levels on reset.

## Timing
- First enabled edge after reset presents (0,0) with DE=1, LINE_START=1 and FRAME_START=1.
- Frame period is H_TOTAL×V_TOTAL enabled cycles. Strobes are exactly one enabled cycle wide.
- *_D outputs equal their source exactly PIPE_DLY enabled cycles earlier. With PIPE_DLY=1 they align with the drawer's RGB register.
- Reset asserted mid-frame: reset values appear without a clock edge. Counting restarts from (0,0) on the first enabled edge after release.
- EN toggling at a wrap point does not skip or repeat any pointer value.

## Structure
- Shared package pong_video_pkg holds:
  - 720p default timing constants;
  - the phase enum typedef (ACT, FP, SYNC, BP);
  - a localparam function for H_TOTAL/V_TOTAL.
- One sub-module, sync_delay_line: parameterised-depth, reset-to-value shift register with enable. Instantiate it three times.
- The two phase FSMs stay inline.

## Test plan
- Reset and release with EN=1 → before the edge H_CNT=1649, V_CNT=749, DE=0; after the first edge (0,0), DE=1, FRAME_START=1, LINE_START=1.
- One line at defaults:
  - DE=1 at H=1279 and 0 at H=1280.
  - HSYNC=1 for H=1390..1429 (40 cycles).
  - H=1649 → 0 with V incremented and LINE_START=1.
- One frame at defaults:
  - FRAME_END at (1279,719).
  - VSYNC=1 from (0,725) through (1649,729).
  - V=749 → 0, and FRAME_START repeats every 1,237,500 cycles.
- EN low for 10 cycles at H=500 → pointers and levels hold and strobes stay 0; H=501 follows the next enabled edge. Repeat at H=1649, V=749.
- RST_N asserted mid-frame between clock edges → all outputs at reset values immediately.
- Small parameter set: H 30/1/2/3, V 20/1/2/3, PIPE_DLY=2, HS_POL=VS_POL=0.
  - HSYNC low at H=31..32; VSYNC low on lines 21..22.
  - DE_D/HSYNC_D lag by exactly 2 enabled cycles, including across an EN gap.

Source files
------------

// File: rtl/pong_video_pkg.sv
// Shared raster timing definitions for the pong video pipeline.
// Holds 720p defaults, the sync phase type and timing helpers.
package pong_video_pkg;

    localparam int unsigned DEF_H_ACTIVE = 1280;
    localparam int unsigned DEF_H_FP     = 110;
    localparam int unsigned DEF_H_SYNC   = 40;
    localparam int unsigned DEF_H_BP     = 220;
    localparam int unsigned DEF_V_ACTIVE = 720;
    localparam int unsigned DEF_V_FP     = 5;
    localparam int unsigned DEF_V_SYNC   = 5;
    localparam int unsigned DEF_V_BP     = 20;

    localparam int unsigned PTR_W     = 11;
    localparam int unsigned MAX_TOTAL = 2048;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_t;

    function automatic int unsigned timing_total(input int unsigned act,
                                                 input int unsigned fp,
                                                 input int unsigned sync,
                                                 input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // Phase order is ACT -> FP -> SYNC -> BP -> ACT for both axes.
    function automatic phase_t phase_next(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH_ACT:  nxt = PH_FP;
            PH_FP:   nxt = PH_SYNC;
            PH_SYNC: nxt = PH_BP;
            default: nxt = PH_ACT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enabled shift register of configurable depth, reset-filled with a fixed level.
module sync_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter logic        INIT  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= INIT;
                end else if (en) begin
                    sr <= d;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= {DEPTH{INIT}};
                end else if (en) begin
                    sr <= {sr[DEPTH-2:0], d};
                end
            end
        end
    endgenerate

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel pointers, sync/DE levels, line/frame strobes
// and delayed sync/DE copies aligned with the drawer's registered RGB.
module video_timing_gen
    import pong_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter int unsigned PIPE_DLY = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    output logic [PTR_W-1:0] H_CNT,
    output logic [PTR_W-1:0] V_CNT,
    output logic             DE,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             LINE_START,
    output logic             FRAME_START,
    output logic             FRAME_END,
    output logic             DE_D,
    output logic             HSYNC_D,
    output logic             VSYNC_D
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [PTR_W-1:0] H_LAST     = PTR_W'(H_TOTAL - 1);
    localparam logic [PTR_W-1:0] V_LAST     = PTR_W'(V_TOTAL - 1);
    localparam logic [PTR_W-1:0] H_ACT_END  = PTR_W'(H_ACTIVE - 1);
    localparam logic [PTR_W-1:0] H_FP_END   = PTR_W'(H_FP - 1);
    localparam logic [PTR_W-1:0] H_SYNC_END = PTR_W'(H_SYNC - 1);
    localparam logic [PTR_W-1:0] H_BP_END   = PTR_W'(H_BP - 1);
    localparam logic [PTR_W-1:0] V_ACT_END  = PTR_W'(V_ACTIVE - 1);
    localparam logic [PTR_W-1:0] V_FP_END   = PTR_W'(V_FP - 1);
    localparam logic [PTR_W-1:0] V_SYNC_END = PTR_W'(V_SYNC - 1);
    localparam logic [PTR_W-1:0] V_BP_END   = PTR_W'(V_BP - 1);

    generate
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
            PIPE_DLY == 0 || H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_params
            $error("video_timing_gen: invalid timing parameters");
        end
    endgenerate

    phase_t           h_phase, h_phase_n, v_phase, v_phase_n;
    logic [PTR_W-1:0] h_pcnt, h_pcnt_n, v_pcnt, v_pcnt_n;
    logic [PTR_W-1:0] h_cnt, h_cnt_n, v_cnt, v_cnt_n;
    logic             h_done, v_done, h_wrap, v_wrap;
    logic             de_c, hsync_c, vsync_c;
    logic             line_start_c, frame_start_c, frame_end_c;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Last count of the current phase on each axis.
    always_comb begin
        h_done = 1'b0;
        v_done = 1'b0;
        case (h_phase)
            PH_ACT:  h_done = (h_pcnt == H_ACT_END);
            PH_FP:   h_done = (h_pcnt == H_FP_END);
            PH_SYNC: h_done = (h_pcnt == H_SYNC_END);
            default: h_done = (h_pcnt == H_BP_END);
        endcase
        case (v_phase)
            PH_ACT:  v_done = (v_pcnt == V_ACT_END);
            PH_FP:   v_done = (v_pcnt == V_FP_END);
            PH_SYNC: v_done = (v_pcnt == V_SYNC_END);
            default: v_done = (v_pcnt == V_BP_END);
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_phase <= PH_BP;
            v_phase <= PH_BP;
            h_pcnt  <= H_BP_END;
            v_pcnt  <= V_BP_END;
            h_cnt   <= H_LAST;
            v_cnt   <= V_LAST;
        end else begin
            h_phase <= h_phase_n;
            v_phase <= v_phase_n;
            h_pcnt  <= h_pcnt_n;
            v_pcnt  <= v_pcnt_n;
            h_cnt   <= h_cnt_n;
            v_cnt   <= v_cnt_n;
        end
    end

    // Vertical side only moves on the horizontal wrap.
    always_comb begin
        h_phase_n = h_phase;
        v_phase_n = v_phase;
        h_pcnt_n  = h_pcnt;
        v_pcnt_n  = v_pcnt;
        h_cnt_n   = h_cnt;
        v_cnt_n   = v_cnt;
        if (EN) begin
            h_cnt_n = h_wrap ? '0 : h_cnt + PTR_W'(1);
            if (h_done) begin
                h_phase_n = phase_next(h_phase);
                h_pcnt_n  = '0;
            end else begin
                h_pcnt_n = h_pcnt + PTR_W'(1);
            end
            if (h_wrap) begin
                v_cnt_n = v_wrap ? '0 : v_cnt + PTR_W'(1);
                if (v_done) begin
                    v_phase_n = phase_next(v_phase);
                    v_pcnt_n  = '0;
                end else begin
                    v_pcnt_n = v_pcnt + PTR_W'(1);
                end
            end
        end
    end

    // Outputs describe the pointer the next edge will present.
    always_comb begin
        de_c          = DE;
        hsync_c       = HSYNC;
        vsync_c       = VSYNC;
        line_start_c  = 1'b0;
        frame_start_c = 1'b0;
        frame_end_c   = 1'b0;
        if (EN) begin
            de_c          = (h_phase_n == PH_ACT) && (v_phase_n == PH_ACT);
            hsync_c       = (h_phase_n == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync_c       = (v_phase_n == PH_SYNC) ? VS_POL : ~VS_POL;
            line_start_c  = (h_cnt_n == '0);
            frame_start_c = (h_cnt_n == '0) && (v_cnt_n == '0);
            frame_end_c   = (h_cnt_n == H_ACT_END) && (v_cnt_n == V_ACT_END);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DE          <= 1'b0;
            HSYNC       <= ~HS_POL;
            VSYNC       <= ~VS_POL;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            FRAME_END   <= 1'b0;
        end else begin
            DE          <= de_c;
            HSYNC       <= hsync_c;
            VSYNC       <= vsync_c;
            LINE_START  <= line_start_c;
            FRAME_START <= frame_start_c;
            FRAME_END   <= frame_end_c;
        end
    end

    assign H_CNT = h_cnt;
    assign V_CNT = v_cnt;

    sync_delay_line #(.DEPTH(PIPE_DLY), .INIT(1'b0)) u_de_dly (
        .clk(CLK), .rst_n(RST_N), .en(EN), .d(DE), .q(DE_D)
    );

    sync_delay_line #(.DEPTH(PIPE_DLY), .INIT(~HS_POL)) u_hs_dly (
        .clk(CLK), .rst_n(RST_N), .en(EN), .d(HSYNC), .q(HSYNC_D)
    );

    sync_delay_line #(.DEPTH(PIPE_DLY), .INIT(~VS_POL)) u_vs_dly (
        .clk(CLK), .rst_n(RST_N), .en(EN), .d(VSYNC), .q(VSYNC_D)
    );

endmodule
